// File: rtl/spmv_seq_ctrl.sv
// Sequencer for a CSR-style sparse matrix-vector datapath: walks nnz elements, tracks row
// boundaries from the end-of-row memory, drains the pipeline and reports completion.
module spmv_seq_ctrl #(
  parameter int unsigned WIDTH_ADDR = 16,
  parameter int unsigned WIDTH_ROW  = 16,
  parameter int unsigned PIPE_DEPTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH_ADDR-1:0] nnz,
  input  logic                  stall,
  input  logic                  eor_in,
  output logic                  elem_rd_en,
  output logic [WIDTH_ADDR-1:0] elem_addr,
  output logic                  clear_acc,
  output logic [WIDTH_ROW-1:0]  row_idx,
  output logic                  row_end,
  output logic                  busy,
  output logic                  done,
  output logic                  err_eor
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                state_q;
  logic [WIDTH_ADDR-1:0] nnz_q;
  logic [WIDTH_ADDR-1:0] addr_q;
  logic [3:0]            drain_cnt_q;
  logic [WIDTH_ROW-1:0]  row_idx_q;
  logic                  eor_vld_q;
  logic                  clear_acc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_eor_q;

  logic rd_fire;
  logic last_rd;
  logic eor_hit;

  // Reads react to stall/abort in the same cycle so no element is issued into a conflict.
  always_comb begin
    rd_fire = (state_q == StFetch) && !stall && !abort;
    last_rd = (addr_q == nnz_q - WIDTH_ADDR'(1));
    eor_hit = eor_vld_q && eor_in && !abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      nnz_q       <= '0;
      addr_q      <= '0;
      drain_cnt_q <= '0;
      row_idx_q   <= '0;
      eor_vld_q   <= 1'b0;
      clear_acc_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_eor_q   <= 1'b0;
    end else begin
      clear_acc_q <= 1'b0;
      done_q      <= 1'b0;
      eor_vld_q   <= rd_fire;
      if (eor_hit) begin
        row_idx_q <= row_idx_q + WIDTH_ROW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            nnz_q       <= nnz;
            addr_q      <= '0;
            row_idx_q   <= '0;
            err_eor_q   <= 1'b0;
            clear_acc_q <= 1'b1;
            if (nnz == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
              busy_q  <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!stall) begin
            // The address parks on the final element rather than running past nnz-1.
            if (last_rd) begin
              state_q     <= StDrain;
              drain_cnt_q <= 4'(PIPE_DEPTH);
            end else begin
              addr_q <= addr_q + WIDTH_ADDR'(1);
            end
          end
        end
        StDrain: begin
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            // Only the final element's EOR qualifier can land inside DRAIN.
            if (eor_vld_q && !eor_in) begin
              err_eor_q <= 1'b1;
            end
            if (drain_cnt_q == 4'd0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (!stall) begin
              drain_cnt_q <= drain_cnt_q - 4'd1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign elem_rd_en = rd_fire;
  assign elem_addr  = addr_q;
  assign clear_acc  = clear_acc_q;
  assign row_idx    = row_idx_q;
  assign row_end    = eor_hit;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_eor    = err_eor_q;

endmodule
